// File: rtl/qif_syn_current.sv
`default_nettype none
// ============================================================================
// Module   : qif_syn_current
// Purpose  : Synapse stage feeding the QIF neuron. Each accepted presynaptic
//            spike vector adds the weights of its set bits, one index per
//            cycle, into a 12-bit saturating accumulator. The accumulator is
//            presented as a registered, saturated signed 8-bit current.
// Option   : `define QIF_SYN_LEAK_EN adds a free-running tick counter and a
//            LEAK state that removes acc/2^DECAY_SHIFT once per tick. Without
//            it the block is a pure integrator.
// Ports    : clk         - clock, all logic on the rising edge
//            rst_n       - synchronous reset, ACTIVE-HIGH despite the name
//            spike_in    - presynaptic spike vector (bit i = input i fired)
//            spike_valid - spike_in is valid
//            spike_ready - a spike vector can be accepted this cycle
//            wr_en       - weight write strobe
//            wr_addr     - weight index to write
//            wr_data     - signed 8-bit weight value
//            I_syn       - signed 8-bit synaptic current
//            I_upd       - one-cycle pulse when I_syn shows a finished
//                          accumulation or leak
// Revision : 1.0 - initial release
// ============================================================================
module qif_syn_current #(
  parameter int N_SYN       = 4,
  parameter int DECAY_SHIFT = 3,
  parameter int TICK_DIV    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SYN-1:0]           spike_in,
  input  logic                       spike_valid,
  output logic                       spike_ready,
  input  logic                       wr_en,
  input  logic [$clog2(N_SYN)-1:0]   wr_addr,
  input  logic [7:0]                 wr_data,
  output logic signed [7:0]          I_syn,
  output logic                       I_upd
);

  localparam int AW = $clog2(N_SYN);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SYN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LEAK  = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic signed [7:0]      weight [N_SYN];
  logic signed [11:0]     acc, acc_nx;
  logic [N_SYN-1:0]       spk;
  logic [AW-1:0]          idx;
  logic                   live;     // low for the cycle after reset so ready rises one cycle late
  logic                   fin, fin_nx;
  logic                   accept;
  logic signed [12:0]     sum;

  function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
    if (v > 13'sd2047)       return 12'sd2047;
    else if (v < -13'sd2048) return -12'sd2048;
    else                     return v[11:0];
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [11:0] v);
    if (v > 12'sd127)       return 8'sd127;
    else if (v < -12'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

`ifdef QIF_SYN_LEAK_EN
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0]      tick;
  logic               leak_pend;
  logic               leak_done;
  logic signed [11:0] delta;

  // A wrap always wins over a same-cycle leak completion so no tick is lost.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tick      <= '0;
      leak_pend <= 1'b0;
    end else if (tick == TW'(TICK_DIV - 1)) begin
      tick      <= '0;
      leak_pend <= 1'b1;
    end else begin
      tick <= tick + 1'b1;
      if (leak_done) leak_pend <= 1'b0;
    end
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    fin_nx      = 1'b0;
    accept      = 1'b0;
    spike_ready = 1'b0;
    sum         = {acc[11], acc} + {{5{weight[idx][7]}}, weight[idx]};
`ifdef QIF_SYN_LEAK_EN
    leak_done   = 1'b0;
    delta       = acc >>> DECAY_SHIFT;
    // Positive values would stall above zero once the shift underflows.
    if (delta == 12'sd0 && acc > 12'sd0) delta = 12'sd1;
`endif
    case (state)
      IDLE: begin
`ifdef QIF_SYN_LEAK_EN
        spike_ready = live & ~leak_pend;
        if (leak_pend) begin
          state_nx = LEAK;
        end else if (spike_valid && spike_ready) begin
          accept   = 1'b1;
          state_nx = ACCUM;
        end
`else
        spike_ready = live;
        if (spike_valid && spike_ready) begin
          accept   = 1'b1;
          state_nx = ACCUM;
        end
`endif
      end
      ACCUM: begin
        if (spk[idx]) acc_nx = sat12(sum);
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
          fin_nx   = 1'b1;
        end
      end
`ifdef QIF_SYN_LEAK_EN
      LEAK: begin
        acc_nx    = sat12({acc[11], acc} - {delta[11], delta});
        leak_done = 1'b1;
        fin_nx    = 1'b1;
        state_nx  = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  // I_syn follows acc one cycle late; I_upd is fin delayed to line up with it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc   <= '0;
      spk   <= '0;
      idx   <= '0;
      live  <= 1'b0;
      fin   <= 1'b0;
      I_syn <= '0;
      I_upd <= 1'b0;
    end else begin
      acc   <= acc_nx;
      live  <= 1'b1;
      fin   <= fin_nx;
      I_syn <= sat8(acc);
      I_upd <= fin;
      if (accept) begin
        spk <= spike_in;
        idx <= '0;
      end else if (state == ACCUM) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Weight table; a same-cycle read of the written index still sees the old value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_SYN; i++) weight[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < N_SYN)) begin
      weight[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire
